// File: rtl/irq_rr_arbiter.sv
// Interrupt pending/arbitration block: latches edge or level requests, masks with MIE,
// picks one source by rotating priority and tracks the claim/service/mret handshake.
module irq_rr_arbiter #(
    parameter int N_SRC = 32,
    parameter int ID_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src_i,
    input  logic [N_SRC-1:0] irq_mie_i,
    input  logic [N_SRC-1:0] irq_edge_i,
    input  logic             irq_claim_i,
    input  logic             irq_done_i,
    output logic             irq_req_o,
    output logic [ID_W-1:0]  irq_id_o,
    output logic [31:0]      irq_mcause_o,
    output logic [N_SRC-1:0] irq_pending_o,
    output logic             irq_busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE
    } state_t;

    state_t             state, state_d;
    logic [N_SRC-1:0]   prev_src;
    logic [N_SRC-1:0]   pending, pending_d;
    logic [N_SRC-1:0]   eligible;
    logic [N_SRC-1:0]   claim_clr;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [ID_W-1:0]    sel;
    logic [ID_W-1:0]    idx;
    logic               found;
    logic               claim_fire;

    assign eligible   = pending & irq_mie_i;
    assign claim_fire = (state == S_REQ) && irq_claim_i;

    // Rotating search starting just after the last serviced id; 5-bit index wraps mod 32.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = last_q + ID_W'(k + 1);
            if (!found && eligible[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        claim_clr = '0;
        if (claim_fire)
            claim_clr[id_q] = 1'b1;
        // Edge bits: a new rising edge beats a same-cycle claim clear. Level bits follow the line.
        pending_d = (irq_edge_i & ((pending & ~claim_clr) | (irq_src_i & ~prev_src)))
                  | (~irq_edge_i & irq_src_i);
    end

    always_comb begin
        state_d = state;
        id_d    = id_q;
        last_d  = last_q;
        unique case (state)
            S_IDLE: begin
                if (eligible != '0) begin
                    id_d    = sel;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (irq_claim_i) begin
                    last_d  = id_q;
                    state_d = S_SERVICE;
                end else if (!eligible[id_q]) begin
                    state_d = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (irq_done_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state    <= S_IDLE;
            prev_src <= '0;
            pending  <= '0;
            id_q     <= '0;
            last_q   <= ID_W'(N_SRC - 1);
        end else begin
            state    <= state_d;
            prev_src <= irq_src_i;
            pending  <= pending_d;
            id_q     <= id_d;
            last_q   <= last_d;
        end
    end

    assign irq_req_o     = (state == S_REQ);
    assign irq_busy_o    = (state == S_SERVICE);
    assign irq_id_o      = id_q;
    assign irq_mcause_o  = {1'b1, {(31 - ID_W){1'b0}}, id_q};
    assign irq_pending_o = pending;

endmodule

// File: tb/tb_irq_rr_arbiter.sv
// Directed self-checking bench for irq_rr_arbiter: edge/level capture, round robin,
// withdrawal, queueing during service, set/clear collision and mid-service reset.
module tb_irq_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] irq_src_i, irq_mie_i, irq_edge_i;
    logic        irq_claim_i, irq_done_i;
    logic        irq_req_o, irq_busy_o;
    logic [4:0]  irq_id_o;
    logic [31:0] irq_mcause_o, irq_pending_o;

    int checks   = 0;
    int failures = 0;

    irq_rr_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .irq_src_i    (irq_src_i),
        .irq_mie_i    (irq_mie_i),
        .irq_edge_i   (irq_edge_i),
        .irq_claim_i  (irq_claim_i),
        .irq_done_i   (irq_done_i),
        .irq_req_o    (irq_req_o),
        .irq_id_o     (irq_id_o),
        .irq_mcause_o (irq_mcause_o),
        .irq_pending_o(irq_pending_o),
        .irq_busy_o   (irq_busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!irq_req_o && n < 10) begin
            tick();
            n++;
        end
        check("req_wait", 32'(irq_req_o), 32'd1);
    endtask

    // Full present/claim/done cycle for one expected grant.
    task automatic grant(input logic [4:0] exp_id);
        wait_req();
        check("rr_id", 32'(irq_id_o), 32'(exp_id));
        irq_claim_i = 1'b1;
        tick();
        irq_claim_i = 1'b0;
        check("rr_busy", 32'(irq_busy_o), 32'd1);
        check("rr_last", 32'(dut.last_q), 32'(exp_id));
        irq_done_i = 1'b1;
        tick();
        irq_done_i = 1'b0;
        check("rr_done_busy", 32'(irq_busy_o), 32'd0);
    endtask

    initial begin
        irq_src_i   = '0;
        irq_mie_i   = 32'hFFFF_FFFF;
        irq_edge_i  = 32'hFFFF_FFFF;
        irq_claim_i = 1'b0;
        irq_done_i  = 1'b0;

        // 1. Reset values, then basic edge pulse on src[3]
        do_reset();
        check("rst_req",     32'(irq_req_o),  32'd0);
        check("rst_busy",    32'(irq_busy_o), 32'd0);
        check("rst_id",      32'(irq_id_o),   32'd0);
        check("rst_mcause",  irq_mcause_o,    32'h8000_0000);
        check("rst_pending", irq_pending_o,   32'h0);
        irq_src_i = 32'h8;
        tick();
        irq_src_i = 32'h0;
        check("e_pending", irq_pending_o, 32'h8);
        check("e_req_early", 32'(irq_req_o), 32'd0);
        tick();
        check("e_req",    32'(irq_req_o), 32'd1);
        check("e_id",     32'(irq_id_o),  32'd3);
        check("e_mcause", irq_mcause_o,   32'h8000_0003);
        irq_claim_i = 1'b1;
        tick();
        irq_claim_i = 1'b0;
        check("e_clr_pending", irq_pending_o,   32'h0);
        check("e_busy",        32'(irq_busy_o), 32'd1);
        check("e_svc_req",     32'(irq_req_o),  32'd0);
        irq_done_i = 1'b1;
        tick();
        irq_done_i = 1'b0;
        check("e_done_busy", 32'(irq_busy_o), 32'd0);
        tick();
        check("e_no_req", 32'(irq_req_o), 32'd0);

        // 2. Round robin between level sources 1 and 5
        irq_edge_i = 32'h0;
        irq_src_i  = 32'h22;
        do_reset();
        grant(5'd1);
        grant(5'd5);
        grant(5'd1);
        grant(5'd5);
        irq_src_i = 32'h0;

        // 3. Withdrawal when mie[7] is cleared in REQ
        do_reset();
        irq_src_i = 32'h80;
        wait_req();
        check("w_id", 32'(irq_id_o), 32'd7);
        irq_mie_i = 32'hFFFF_FF7F;
        tick();
        check("w_req",  32'(irq_req_o),  32'd0);
        check("w_busy", 32'(irq_busy_o), 32'd0);
        tick();
        tick();
        check("w_no_req", 32'(irq_req_o), 32'd0);
        irq_src_i = 32'h0;
        irq_mie_i = 32'hFFFF_FFFF;

        // 4. Edge event queued while id 4 is in service
        irq_edge_i = 32'hFFFF_FFFF;
        do_reset();
        irq_src_i = 32'h10;
        tick();
        irq_src_i = 32'h0;
        wait_req();
        check("q_id4", 32'(irq_id_o), 32'd4);
        irq_claim_i = 1'b1;
        tick();
        irq_claim_i = 1'b0;
        irq_src_i = 32'h4;
        tick();
        irq_src_i = 32'h0;
        tick();
        check("q_pending2", irq_pending_o,   32'h4);
        check("q_svc_req",  32'(irq_req_o),  32'd0);
        check("q_svc_busy", 32'(irq_busy_o), 32'd1);
        irq_done_i = 1'b1;
        tick();
        irq_done_i = 1'b0;
        check("q_idle_req", 32'(irq_req_o), 32'd0);
        tick();
        check("q_req", 32'(irq_req_o), 32'd1);
        check("q_id2", 32'(irq_id_o),  32'd2);

        // 5. Rising edge on src[3] in the same cycle as its claim
        do_reset();
        irq_src_i = 32'h8;
        tick();
        irq_src_i = 32'h0;
        tick();
        check("c_req", 32'(irq_req_o), 32'd1);
        check("c_id",  32'(irq_id_o),  32'd3);
        irq_src_i   = 32'h8;
        irq_claim_i = 1'b1;
        tick();
        irq_claim_i = 1'b0;
        irq_src_i   = 32'h0;
        check("c_pending_kept", irq_pending_o,   32'h8);
        check("c_busy",         32'(irq_busy_o), 32'd1);
        irq_done_i = 1'b1;
        tick();
        irq_done_i = 1'b0;
        tick();
        check("c_rereq", 32'(irq_req_o), 32'd1);
        check("c_reid",  32'(irq_id_o),  32'd3);

        // 6. Reset asserted mid-SERVICE
        do_reset();
        irq_src_i = 32'h10;
        tick();
        irq_src_i = 32'h0;
        wait_req();
        irq_claim_i = 1'b1;
        tick();
        irq_claim_i = 1'b0;
        check("r_busy_pre", 32'(irq_busy_o), 32'd1);
        reset = 1'b1;
        tick();
        check("r_req",     32'(irq_req_o),  32'd0);
        check("r_busy",    32'(irq_busy_o), 32'd0);
        check("r_pending", irq_pending_o,   32'h0);
        check("r_id",      32'(irq_id_o),   32'd0);
        check("r_mcause",  irq_mcause_o,    32'h8000_0000);
        reset      = 1'b0;
        irq_done_i = 1'b1;
        tick();
        irq_done_i = 1'b0;
        check("r_done_busy", 32'(irq_busy_o), 32'd0);
        check("r_done_req",  32'(irq_req_o),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_rr_arbiter.md
Name: irq_rr_arbiter

Overview:
Interrupt pending/arbitration block between peripheral IRQ lines and the core's trap logic.
- Latches edge-type requests, masks them with MIE and picks one source by rotating (round-robin) priority.
- Presents that source as a single request with mcause, then tracks the claim/service/mret handshake with the core.
- Only one interrupt is in service at a time; no nesting.

Parameters:
N_SRC, 32, number of interrupt sources (fixed at 32; ID width follows)
ID_W, 5, width of source id

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
irq_src_i  input  32  raw interrupt lines from devices
irq_mie_i  input  32  per-source enable mask (from CSR mie)
irq_edge_i  input  32  per-source trigger type: 1 = rising-edge latched, 0 = level
irq_claim_i  input  1  core takes the trap for the presented id (1-cycle pulse)
irq_done_i  input  1  core finished handler (mret), 1-cycle pulse
irq_req_o  output  1  interrupt request to core
irq_id_o  output  5  id of presented/in-service source
irq_mcause_o  output  32  {1'b1, 26'b0, irq_id_o}
irq_pending_o  output  32  current pending vector
irq_busy_o  output  1  handler in service

Behaviour:
- Reset: state IDLE; pending=0, prev_src=0, id_q=0, last_q=31. All outputs 0, except irq_mcause_o=0x80000000. Reset overrides every other event in the same cycle.
- Source capture, evaluated each posedge:
  - prev_src <= irq_src_i.
  - Edge bit: pending[i] set on irq_src_i[i] & ~prev_src[i]; held until cleared by claim.
  - Level bit: pending[i] <= irq_src_i[i] every cycle; claim has no effect.
  - A rising edge and a claim clear on the same edge bit in the same cycle: set wins, so no event is lost.
  - prev_src resets to 0, so an edge line already high at reset release registers one event.
- eligible = pending & irq_mie_i, combinational.
- Selection:
  - Search order: last_q+1, last_q+2, ..., last_q, all mod 32.
  - The first eligible bit in that order is sel. Combinational; registered only on the IDLE->REQ transition.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if eligible != 0, set id_q <= sel and go to REQ. irq_req_o=0, irq_busy_o=0.
  - REQ: irq_req_o=1 and id_q is frozen.
    - On irq_claim_i: clear pending[id_q] if it is an edge source, set last_q <= id_q, go to SERVICE.
    - Else if eligible[id_q]==0 (masked, or level line dropped): withdraw to IDLE; irq_req_o low next cycle.
    - Claim and withdrawal in the same cycle: claim wins.
  - SERVICE: irq_req_o=0, irq_busy_o=1. On irq_done_i go to IDLE. New pending bits keep accumulating.
  - Ignored inputs: irq_claim_i outside REQ; irq_done_i outside SERVICE.
- Latency:
  - Edge source high at posedge k gives pending at k.
  - irq_req_o=1 after posedge k+1.
  - After done at posedge d, the next request appears after posedge d+1 (IDLE is occupied for one cycle).
- Outputs:
  - irq_id_o = id_q, holding its last value in IDLE.
  - irq_mcause_o is derived from id_q.
  - irq_pending_o = pending (unmasked).
  - irq_req_o and irq_busy_o are decoded from registered state; no combinational path from any input.
- Reset asserted mid-REQ or mid-SERVICE: everything returns to reset values next cycle and the in-flight interrupt is dropped.

Test Plan:
1. Basic edge: reset, mie=0xFFFFFFFF, edge=0xFFFFFFFF, 1-cycle pulse on src[3].
   - Response: pending=0x8, irq_req_o=1 the following cycle, id=3, mcause=0x80000003.
   - Claim: pending=0, busy=1.
   - Done: busy=0, req stays 0.
2. Round robin: edge=0, src[1] and src[5] held high.
   - Response: successive grants 1, 5, 1, 5.
   - Every claim->done cycle ends with last_q equal to the granted id.
3. Withdraw: level src[7] presented in REQ, then clear mie[7] before claim.
   - Response: irq_req_o=0 next cycle, state IDLE.
   - With no other eligible source, no further request.
4. Queue during service: SERVICE on id 4, edge pulse on src[2].
   - During service: pending[2]=1 and req stays 0.
   - After done: req=1 with id=2 two cycles later.
5. Set/clear collision: edge src[3] in REQ, second rising edge on src[3] in the claim cycle.
   - Response: pending[3] stays 1 after claim; id 3 is re-presented after done.
6. Reset mid-SERVICE: assert reset.
   - Response: req=0, busy=0, pending=0, id=0, mcause=0x80000000 next cycle.
   - A done pulse after reset is ignored.
